// File: rtl/pipe_hazard_pkg.sv
// Shared defaults, slot record and width helper for the hazard scoreboard.
// Slot fields are sized for the largest legal configuration so one typedef serves every build.
package pipe_hazard_pkg;

    localparam int AW_DEF     = 5;
    localparam int STAGES_DEF = 3;
    localparam int NSRC_DEF   = 2;

    // Upper bounds: AW must not exceed AW_MAX, STAGES is at most 7.
    localparam int AW_MAX   = 16;
    localparam int LATW_MAX = 3;

    typedef struct packed {
        logic                v;
        logic                regwr;
        logic [AW_MAX-1:0]   rd;
        logic [LATW_MAX-1:0] lat;
    } slot_t;

    function automatic int selw_f(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// Youngest-producer search for one source operand over the forwardable slots.
// Purely combinational; hit/k select the forward source, need_stall flags an unready result.
module pipe_hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int SELW   = selw_f(STAGES)
) (
    input  slot_t           slots_i [STAGES-1],
    input  logic [AW-1:0]   rs_i,
    output logic            hit_o,
    output logic [SELW-1:0] k_o,
    output logic            need_stall_o
);

    logic [LATW_MAX-1:0] lat_w;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        k_o   = '0;
        lat_w = '0;
        for (int j = STAGES - 2; j >= 0; j--) begin
            if (slots_i[j].v && slots_i[j].regwr && (rs_i != '0) &&
                (slots_i[j].rd == AW_MAX'(rs_i))) begin
                hit_o = 1'b1;
                k_o   = SELW'(j + 1);
                lat_w = slots_i[j].lat;
            end
        end
        need_stall_o = hit_o && ((int'(k_o) + 1) <= int'(lat_w));
    end

endmodule

// File: rtl/pipe_hazard_sb.sv
// Scoreboard for RAW hazards: tracks in-flight producers, raises stall, registers forward selects.
// stall is combinational from ID; fwd_sel and stall_cnt update one edge after the ID decision.
module pipe_hazard_sb
    import pipe_hazard_pkg::*;
#(
    parameter  int AW     = AW_DEF,
    parameter  int STAGES = STAGES_DEF,
    parameter  int NSRC   = NSRC_DEF,
    localparam int SELW   = selw_f(STAGES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic                 id_regwr,
    input  logic [AW-1:0]        id_rd,
    input  logic [SELW-1:0]      id_lat,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic [15:0]          stall_cnt
);

    // Slot STAGES is served by the write-through register file and never
    // forwards, so only slots 1..STAGES-1 are kept (index j holds slot j+1).
    slot_t               slots_q [STAGES-1];
    slot_t               slots_d [STAGES-1];
    logic [NSRC*SELW-1:0] fwd_sel_q, fwd_sel_d;
    logic [15:0]          cnt_q, cnt_d;

    logic [NSRC-1:0]     hit_w;
    logic [NSRC-1:0]     need_w;
    logic [SELW-1:0]     k_w [NSRC];
    logic [LATW_MAX-1:0] lat_n;
    logic                advance;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        pipe_hazard_match #(
            .AW     (AW),
            .STAGES (STAGES),
            .SELW   (SELW)
        ) u_match (
            .slots_i      (slots_q),
            .rs_i         (id_rs[i*AW +: AW]),
            .hit_o        (hit_w[i]),
            .k_o          (k_w[i]),
            .need_stall_o (need_w[i])
        );
    end

    always_comb begin
        if (id_lat == '0) begin
            lat_n = LATW_MAX'(1);
        end else if (int'(id_lat) > STAGES) begin
            lat_n = LATW_MAX'(STAGES);
        end else begin
            lat_n = LATW_MAX'(id_lat);
        end
    end

    always_comb begin
        stall   = id_valid && !flush && !reset && (|need_w);
        advance = id_valid && !stall && !flush;

        slots_d[0] = '0;
        if (advance) begin
            slots_d[0].v     = 1'b1;
            slots_d[0].regwr = id_regwr;
            slots_d[0].rd    = AW_MAX'(id_rd);
            slots_d[0].lat   = lat_n;
        end
        for (int j = 1; j < STAGES - 1; j++) begin
            slots_d[j] = slots_q[j-1];
        end

        // The producer moves one slot further at the same edge, hence k+1.
        fwd_sel_d = '0;
        if (advance) begin
            for (int i = 0; i < NSRC; i++) begin
                if (hit_w[i]) begin
                    fwd_sel_d[i*SELW +: SELW] = k_w[i] + SELW'(1);
                end
            end
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < STAGES - 1; j++) begin
                slots_q[j] <= '0;
            end
            fwd_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int j = 0; j < STAGES - 1; j++) begin
                slots_q[j] <= slots_d[j];
            end
            fwd_sel_q <= fwd_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_hazard_sb.md
PIPE_HAZARD_SB -- requirements
Module: pipe_hazard_sb

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter STAGES, default 3, tracked stages from EX onward (slot 1 = EX, slot STAGES = WB); legal range 2..7.
REQ-003 Parameter NSRC, default 2, source operands per instruction.
REQ-004 Localparam SELW = clog2(STAGES+1), forward-select width.
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 id_valid  input  1  valid instruction in ID.
REQ-008 id_rs  input  NSRC*AW  source register addresses; source i in bits [i*AW +: AW].
REQ-009 id_regwr  input  1  ID instruction writes a register.
REQ-010 id_rd  input  AW  ID destination register.
REQ-011 id_lat  input  SELW  first slot whose output can forward this result (1 = ALU, 2 = load).
REQ-012 flush  input  1  squash the ID instruction this cycle.
REQ-013 stall  output  1  hold IF/ID; combinational.
REQ-014 fwd_sel  output  NSRC*SELW  per-source select for the EX instruction: 0 = register file, k = slot k result; registered.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 Each slot SHALL hold {v, regwr, rd, lat}; slots SHALL shift every cycle: slot k+1 <= slot k, and slot STAGES is retired.
REQ-017 Slot 1 SHALL load {1, id_regwr, id_rd, id_lat} when id_valid & !stall & !flush; otherwise it SHALL load a bubble (v=0).
REQ-018 A slot matches source rs iff v & regwr & rd==rs & rs!=0.
REQ-019 For each source, only slots 1..STAGES-1 SHALL be searched; the smallest-index (youngest) match k wins; slot STAGES is covered by the write-through register file.
REQ-020 Source i needs a stall iff winning match k satisfies k+1 <= lat of that slot.
REQ-021 stall SHALL be 1 iff id_valid & !flush & !reset & any source needs a stall.
REQ-022 On an advance (REQ-017 load condition), fwd_sel[i] SHALL be set at the next edge to k+1 for winning match k, else 0.
REQ-023 On a bubble, flush or stall, fwd_sel SHALL be set to all zeros at the next edge.
REQ-024 id_lat = 0 SHALL be treated as 1; id_lat > STAGES SHALL be treated as STAGES.
REQ-025 stall_cnt SHALL increment on each cycle with stall=1 and SHALL hold at 16'hFFFF.
REQ-026 Flush together with a stall condition SHALL give stall=0 and insert a bubble.

Reset
REQ-027 When reset is high at a clock edge, all slot v bits, fwd_sel and stall_cnt SHALL be set to 0.
REQ-028 While reset is high, stall SHALL read 0, including the cycle before the first edge.
REQ-029 When reset is asserted mid-operation, all in-flight entries SHALL be discarded; no forward SHALL reference a pre-reset producer.

Structure
REQ-030 Package pipe_hazard_pkg SHALL hold: the default AW/STAGES/NSRC, the slot struct typedef, and the SELW clog2 function.
REQ-031 Sub-module pipe_hazard_match SHALL implement the per-source youngest-match search, returning hit, k and need_stall; it is instantiated NSRC times.
REQ-032 No other state is permitted: slot array, fwd_sel register and stall_cnt only.

Verification (STAGES=3, NSRC=2)
REQ-033 Issue rd=5 lat=1, then rs0=5 -> stall=0; fwd_sel[0]=2 in the next cycle.
REQ-034 Issue rd=7 lat=2, then rs1=7 -> stall=1 for exactly one cycle, stall_cnt=1; after the retry, fwd_sel[1]=3.
REQ-035 Issue rd=4 lat=1 at cycles 0 and 1, then rs0=4 at cycle 2 -> fwd_sel[0]=2 (youngest wins, not 3); a rd=4 producer three issues back -> fwd_sel[0]=0.
REQ-036 A producer with rd=0 or regwr=0, then rs0=0 and rs1=0 -> stall=0, fwd_sel=0.
REQ-037 Load-use stall with flush=1 in the same cycle -> stall=0; slot 1 is a bubble; fwd_sel=0 in the next cycle.
REQ-038 Reset asserted with 3 valid slots -> next cycle: fwd_sel=0, stall_cnt=0, and a consumer of those rds gets fwd_sel=0 with no stall.
